// File: rtl/seq_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_div_pkg
// Description : Shared types and helpers for the sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_div_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Step-counter width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_div_datapath.sv
`default_nettype none
// ============================================================================
// Module      : Div_Datapath
// Description : Partial-remainder/quotient shift registers, restoring
//               subtractor, step counter and result registers.
//               SEQ_DIV_SIGNED_EN adds sign fix-up of the results.
// Revision    : 1.0 - initial release
// ============================================================================
module Div_Datapath
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               finish_i,
    input  logic               err_dz_i,
    input  logic               err_ovf_i,
    input  logic [2*WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic               neg_quot_i,
    input  logic               neg_rem_i,
`endif
    output logic               last_o,
    output logic [WIDTH-1:0]   quotient_o,
    output logic [WIDTH-1:0]   remainder_o,
    output logic               div_zero_o,
    output logic               overflow_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dz_q, dz_d, ovf_q, ovf_d;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub, w_quot, w_rem;
    logic             w_ge, w_err, w_post_ovf;

    // After a restore R < divisor, so W bits hold R; the shifted value needs W+1.
    assign w_shift = {r_q, q_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, dvs_q});
    assign w_sub   = w_shift[WIDTH-1:0] - dvs_q;
    assign w_err   = err_dz_i | err_ovf_i;
    assign last_o  = (cnt_q == CW'(WIDTH-1));

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_quot_q, neg_rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (load_i) begin
            neg_quot_q <= neg_quot_i;
            neg_rem_q  <= neg_rem_i;
        end
    end

    assign w_quot     = neg_quot_q ? -q_q : q_q;
    assign w_rem      = neg_rem_q ? -r_q : r_q;
    assign w_post_ovf = neg_quot_q ? (q_q > {1'b1, {(WIDTH-1){1'b0}}}) : q_q[WIDTH-1];
`else
    assign w_quot     = q_q;
    assign w_rem      = r_q;
    assign w_post_ovf = 1'b0;
`endif

    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
        if (load_i) begin
            r_d   = dividend_i[2*WIDTH-1:WIDTH];
            q_d   = dividend_i[WIDTH-1:0];
            dvs_d = divisor_i;
            cnt_d = '0;
        end else if (step_i) begin
            r_d   = w_ge ? w_sub : w_shift[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], w_ge};
            cnt_d = cnt_q + CW'(1);
        end
        if (finish_i) begin
            dz_d = err_dz_i;
            // On the error path Q was never shifted and still holds the raw low dividend.
            if (w_err) begin
                quot_d = '1;
                rem_d  = q_q;
                ovf_d  = err_ovf_i;
            end else begin
                quot_d = w_quot;
                rem_d  = w_rem;
                ovf_d  = w_post_ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            q_q    <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
        end
    end

    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign div_zero_o  = dz_q;
    assign overflow_o  = ovf_q;

endmodule
`default_nettype wire

// File: rtl/seq_div_top.sv
`default_nettype none
// ============================================================================
// Module      : seq_div_top
// Description : Sequential restoring divider (2W / W -> W quotient, W
//               remainder), one quotient bit per clock, start/ready handshake.
//               Optional two's-complement mode: define SEQ_DIV_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_div_top
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0]   Divisor,
    output logic               ready,
    output logic [WIDTH-1:0]   Quotient,
    output logic [WIDTH-1:0]   Remainder,
    output logic               div_zero,
    output logic               overflow
);

    div_state_t state_q, state_d;
    logic       ready_q;
    logic       err_dz_q, err_dz_d, err_ovf_q, err_ovf_d, settle_q, settle_d;

    logic               w_dz, w_ovf, w_last, w_step, w_finish, w_accept;
    logic [2*WIDTH-1:0] w_mag_dvd, w_load_dvd;
    logic [WIDTH-1:0]   w_mag_dvs;

`ifdef SEQ_DIV_SIGNED_EN
    logic w_neg_dvd, w_neg_dvs;
    assign w_neg_dvd = Dividend[2*WIDTH-1];
    assign w_neg_dvs = Divisor[WIDTH-1];
    assign w_mag_dvd = w_neg_dvd ? -Dividend : Dividend;
    assign w_mag_dvs = w_neg_dvs ? -Divisor : Divisor;
`else
    assign w_mag_dvd = Dividend;
    assign w_mag_dvs = Divisor;
`endif

    assign w_dz       = (Divisor == '0);
    assign w_ovf      = !w_dz && (w_mag_dvd[2*WIDTH-1:WIDTH] >= w_mag_dvs);
    assign w_accept   = (state_q == IDLE) && start;
    assign w_load_dvd = (w_dz || w_ovf) ? {w_mag_dvd[2*WIDTH-1:WIDTH], Dividend[WIDTH-1:0]}
                                        : w_mag_dvd;

    always_comb begin
        state_d   = state_q;
        err_dz_d  = err_dz_q;
        err_ovf_d = err_ovf_q;
        settle_d  = settle_q;
        unique case (state_q)
            IDLE: if (start) begin
                err_dz_d  = w_dz;
                err_ovf_d = w_ovf;
                settle_d  = 1'b0;
                state_d   = (w_dz || w_ovf) ? DONE : CALC;
            end
            CALC: if (w_last) state_d = DONE;
            // Error results dwell one extra cycle so they report two edges after accept.
            DONE: begin
                settle_d = 1'b1;
                if (!(err_dz_q || err_ovf_q) || settle_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign w_step   = (state_q == CALC);
    assign w_finish = (state_q == DONE) && (state_d == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            err_dz_q  <= 1'b0;
            err_ovf_q <= 1'b0;
            settle_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d == IDLE);
            err_dz_q  <= err_dz_d;
            err_ovf_q <= err_ovf_d;
            settle_q  <= settle_d;
        end
    end

    assign ready = ready_q;

    Div_Datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_accept),
        .step_i     (w_step),
        .finish_i   (w_finish),
        .err_dz_i   (err_dz_q),
        .err_ovf_i  (err_ovf_q),
        .dividend_i (w_load_dvd),
        .divisor_i  (w_mag_dvs),
`ifdef SEQ_DIV_SIGNED_EN
        .neg_quot_i (w_neg_dvd ^ w_neg_dvs),
        .neg_rem_i  (w_neg_dvd),
`endif
        .last_o     (w_last),
        .quotient_o (Quotient),
        .remainder_o(Remainder),
        .div_zero_o (div_zero),
        .overflow_o (overflow)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_div_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_div_top
// Description : Scoreboard bench for seq_div_top (unsigned build, WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_div_top;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
        int           lat;
        int           acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           ready, div_zero, overflow;
    logic [W-1:0]   quotient, remainder;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_ready = 1'b1;

    seq_div_top #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Dividend (dividend),
        .Divisor  (divisor),
        .ready    (ready),
        .Quotient (quotient),
        .Remainder(remainder),
        .div_zero (div_zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division; an unrepresentable quotient is an overflow.
    function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                                   input int acc);
        exp_t           e;
        longint unsigned n;
        longint unsigned d;
        n = dvd;
        d = dvs;
        e.acc = acc;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        if (d == 0) begin
            e.dz = 1'b1; e.q = '1; e.r = dvd[W-1:0]; e.lat = 2;
        end else if (n / d > 64'hFFFF) begin
            e.ovf = 1'b1; e.q = '1; e.r = dvd[W-1:0]; e.lat = 2;
        end else begin
            e.q = W'(n / d); e.r = W'(n % d); e.lat = W + 1;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a rising ready marks a completion; compare against the oldest expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_ready <= 1'b1;
        end else begin
            if (ready && !prev_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("quotient",  64'(quotient),  64'(mon_e.q));
                    check("remainder", 64'(remainder), 64'(mon_e.r));
                    check("div_zero",  64'(div_zero),  64'(mon_e.dz));
                    check("overflow",  64'(overflow),  64'(mon_e.ovf));
                    check("latency",   64'(cyc - mon_e.acc), 64'(mon_e.lat));
                end
            end
            prev_ready <= ready;
        end
    end

    task automatic issue(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, input bit keep);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 64'(ready), 64'd1);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        sb.push_back(model(dvd, dvs, cyc + 1));
        @(negedge clk);
        if (!keep) start = 1'b0;
        dividend = $urandom;
        divisor  = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ready"},     64'(ready),     64'd1);
        check({tag, "_quotient"},  64'(quotient),  64'd0);
        check({tag, "_remainder"}, 64'(remainder), 64'd0);
        check({tag, "_div_zero"},  64'(div_zero),  64'd0);
        check({tag, "_overflow"},  64'(overflow),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        longint unsigned qq, rr;
        bit             keep;

        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_idle_zero("reset");

        issue(32'd100, 16'd7, 1'b0);
        drain();
        issue(32'hFFFE_0001, 16'hFFFF, 1'b0);
        issue(32'd1234, 16'd0, 1'b0);
        issue(32'h0001_0000, 16'd1, 1'b0);
        drain();

        // Start pulse while busy must neither queue nor disturb the operands.
        issue(32'd1000, 16'd9, 1'b0);
        @(negedge clk);
        start = 1'b1; dividend = 32'd5; divisor = 16'd1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Asynchronous reset part-way through an operation.
        issue(32'd100, 16'd7, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle_zero("midreset");
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        issue(32'd100, 16'd7, 1'b0);
        drain();

        for (int i = 0; i < 40; i++) begin
            dvs = W'($urandom_range(1, 65535));
            qq  = $urandom_range(0, 65535);
            rr  = $urandom_range(0, int'(dvs) - 1);
            dvd = 32'(qq * dvs + rr);
            case ($urandom_range(0, 9))
                0: begin dvs = '0; dvd = $urandom; end
                1: dvd = $urandom;
                default: ;
            endcase
            keep = (i < 39) && ($urandom_range(0, 1) == 1);
            issue(dvd, dvs, keep);
        end
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
